uart_bus_master: RTL and testbench
==================================

# uart_bus_master

Serial-to-bus bridge initiator. Consumes command bytes from the UART receive stream, issues single-word read/write transactions on the system bus as a master (driving the `cs_`/`as_`/`rw`/`addr`/`wr_data` side and sampling `rd_data`/`rdy_`), and returns status and read data through the UART transmit stream. It sits between a uart_rx/uart_tx pair and the bus, and provides external memory and peripheral access for loading and debug.

## Interface

**Parameters**

- `TIMEOUT`, default 256: bus cycles to wait for `rdy_` before aborting. Legal range 2..65535.

**Ports**

- `clk` input, 1: system clock.
- `reset` input, 1: asynchronous, active-low reset.
- `rx_end` input, 1: one-cycle pulse; `rx_data` holds a valid received byte.
- `rx_data` input, 8: received byte.
- `tx_start` output, 1: one-cycle pulse that starts transmission of `tx_data`.
- `tx_data` output, 8: byte to transmit; held stable until `tx_end`.
- `tx_end` input, 1: one-cycle pulse when the transmitter finishes a byte.
- `cs_` output, 1: bus chip select, active-low.
- `as_` output, 1: bus address strobe, active-low.
- `rw` output, 1: 1 = read, 0 = write.
- `addr` output, 30: word address.
- `wr_data` output, 32: write data.
- `rd_data` input, 32: read data, valid when `rdy_` is low.
- `rdy_` input, 1: slave ready, active-low.
- `busy` output, 1: high whenever the FSM is not in IDLE.

## Operation

**Frame format** (bytes in `rx_end` order, multi-byte fields MSB first):

- Write command: `0x57`, 4 address bytes, 4 data bytes.
- Read command: `0x52`, 4 address bytes.
- The address is a byte address. `addr` is driven from bits [31:2]; bits [1:0] are ignored.

**States**

- **IDLE.** On `rx_end`:
  - `0x57`: set op=write, go to ADDR.
  - `0x52`: set op=read, go to ADDR.
  - Any other byte: queue `0x15` (NAK) and go to SEND.
- **ADDR.** Shift in 4 bytes using a 2-bit counter. After the 4th byte, go to DATA if op=write, otherwise go to BUS.
- **DATA.** Shift 4 bytes into `wr_data`, then go to BUS.
- **BUS.**
  - Drive `cs_=0`, `as_=0`, `rw=op` and hold them. `addr` and `wr_data` stay stable.
  - Increment the timeout counter every cycle.
  - If `rdy_==0` is sampled: capture `rd_data` (reads only), queue `0x06` (ACK), plus 4 data bytes for a read, then go to SEND.
  - If the counter reaches `TIMEOUT-1` with `rdy_` still high: queue `0x15` and go to SEND.
- **SEND.**
  - Pulse `tx_start` with the next queued byte.
  - Wait for `tx_end`, then send the following byte.
  - After the last `tx_end`, go to IDLE.

**Rules**

- `rx_end` in BUS or SEND is dropped and has no effect.
- The bus is never driven outside BUS.
- `tx_start` is never issued while a byte is outstanding (between a `tx_start` and its `tx_end`).
- `rdy_` and `rd_data` are ignored outside BUS.

**Reset values** (any time `reset` is low, including mid-frame or mid-transaction; the FSM returns to IDLE and partial frames are discarded):

- `cs_=1`, `as_=1`, `rw=1`, `addr=0`, `wr_data=0`
- `tx_start=0`, `tx_data=0`
- `busy=0`

## Timing

- Final command byte `rx_end` at cycle T: `cs_`/`as_` go low at T+1.
- `rdy_` sampled low at cycle S:
  - `cs_`/`as_` go high at S+1, and `rd_data` is registered at S+1.
  - `tx_start` pulses at S+1 with `tx_data=0x06`.
- `rdy_` already low at T+1 gives a single-cycle access; `cs_`/`as_` are low for exactly one cycle.
- Timeout: the strobe is low for exactly `TIMEOUT` cycles, deasserts the following cycle, and `tx_start` carries `0x15` in that same cycle.
- Between bytes: `tx_end` at cycle E gives the next `tx_start` at E+1. Read data goes out in order [31:24], [23:16], [15:8], [7:0].
- Invalid opcode at cycle T: `tx_start` with `0x15` at T+1.
- `busy` rises the cycle after the first accepted byte and falls the cycle after the last `tx_end`.

## Test plan

1. **Write.** Send `57 00 00 01 04 DE AD BE EF`; slave returns `rdy_` low 3 cycles after `as_`.
   - Expect `addr=0x00000041`, `rw=0`, `wr_data=0xDEADBEEF`.
   - Strobe low 4 cycles.
   - One TX byte `0x06`.
2. **Read.** Send `52 00 00 00 08`; slave returns `rd_data=0x12345678` with immediate `rdy_`.
   - Expect `addr=0x2`, `rw=1`, strobe low 1 cycle.
   - TX `06 12 34 56 78`, each `tx_start` one cycle after the previous `tx_end`.
3. **Timeout.** `TIMEOUT=8`, `rdy_` held high on a read.
   - Strobe low exactly 8 cycles, then released.
   - TX `0x15`.
   - Next valid frame completes normally.
4. **Bad opcode and dropped bytes.** Send `0x41`.
   - Expect TX `0x15` and no bus activity.
   - Bytes arriving during SEND are ignored; a following valid frame decodes correctly.
5. **Reset mid-operation.** Assert `reset` low while in BUS after a write frame, then release.
   - Expect `cs_=as_=1`, `busy=0`, `tx_start=0` immediately.
   - A subsequent read frame gets a correct response.

Source files
------------

// File: rtl/uart_bus_master.sv
// uart_bus_master: UART command stream to single-word bus read/write bridge with ACK/NAK and read-data reply.
module uart_bus_master #(
  parameter int TIMEOUT = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_end,
  input  logic [7:0]  rx_data,
  output logic        tx_start,
  output logic [7:0]  tx_data,
  input  logic        tx_end,
  output logic        cs_,
  output logic        as_,
  output logic        rw,
  output logic [29:0] addr,
  output logic [31:0] wr_data,
  input  logic [31:0] rd_data,
  input  logic        rdy_,
  output logic        busy
);
  typedef enum logic [2:0] {IDLE, ADDR, DATA, BUS, SEND} state_t;
  state_t state, state_nxt;
  logic        op;
  logic [1:0]  cnt;
  logic [31:0] addr_r, rdq;
  logic [15:0] tmo;
  logic [2:0]  left;
  logic        pend;
  logic        tmo_hit;
  assign tmo_hit  = tmo == 16'(TIMEOUT - 1);
  assign cs_      = state != BUS;
  assign as_      = state != BUS;
  assign rw       = state == BUS ? op : 1'b1;
  assign addr     = addr_r[31:2];
  assign busy     = state != IDLE;
  assign tx_start = state == SEND && !pend;
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (rx_end) state_nxt = (rx_data == 8'h57 || rx_data == 8'h52) ? ADDR : SEND;
      ADDR: if (rx_end && cnt == 2'd3) state_nxt = op ? BUS : DATA;
      DATA: if (rx_end && cnt == 2'd3) state_nxt = BUS;
      BUS:  if (!rdy_ || tmo_hit) state_nxt = SEND;
      SEND: if (tx_end && pend && left == 3'd0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      op      <= 1'b1;
      cnt     <= 2'd0;
      addr_r  <= '0;
      wr_data <= '0;
      rdq     <= '0;
      tmo     <= '0;
      left    <= '0;
      pend    <= 1'b0;
      tx_data <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (rx_end) begin
          op      <= rx_data == 8'h52;
          cnt     <= 2'd0;
          left    <= 3'd0;
          pend    <= 1'b0;
          tx_data <= 8'h15;
        end
        ADDR: if (rx_end) begin
          addr_r <= {addr_r[23:0], rx_data};
          cnt    <= cnt + 2'd1;
          tmo    <= '0;
        end
        DATA: if (rx_end) begin
          wr_data <= {wr_data[23:0], rx_data};
          cnt     <= cnt + 2'd1;
          tmo     <= '0;
        end
        BUS: begin
          tmo <= tmo + 16'd1;
          // a ready seen on the final timeout cycle still counts as success
          if (!rdy_ || tmo_hit) begin
            tx_data <= rdy_ ? 8'h15 : 8'h06;
            rdq     <= rd_data;
            left    <= (!rdy_ && op) ? 3'd4 : 3'd0;
            pend    <= 1'b0;
          end
        end
        SEND: if (tx_start) pend <= 1'b1;
        else if (tx_end && pend && left != 3'd0) begin
          tx_data <= rdq[31:24];
          rdq     <= rdq << 8;
          left    <= left - 3'd1;
          pend    <= 1'b0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_bus_master.sv
// tb_uart_bus_master: randomized frames checked against a frame-level model of the bridge.
module tb_uart_bus_master;
  localparam int TMO = 8;
  logic        clk = 1'b0, reset = 1'b0, rx_end = 1'b0, tx_end = 1'b0, rdy_ = 1'b1;
  logic [7:0]  rx_data = '0;
  logic [31:0] rd_data = '0;
  logic        tx_start, cs_, as_, rw, busy;
  logic [7:0]  tx_data;
  logic [29:0] addr;
  logic [31:0] wr_data;
  int n_chk = 0, n_err = 0;
  always #5 clk = ~clk;
  uart_bus_master #(.TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .rx_end(rx_end), .rx_data(rx_data),
    .tx_start(tx_start), .tx_data(tx_data), .tx_end(tx_end),
    .cs_(cs_), .as_(as_), .rw(rw), .addr(addr), .wr_data(wr_data),
    .rd_data(rd_data), .rdy_(rdy_), .busy(busy)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    rx_end  = 1'b1;
    rdy_    = 1'($urandom_range(0, 1));
    tick;
    rx_end  = 1'b0;
  endtask
  task automatic run_frame(input logic [7:0] op, input logic [31:0] a, input logic [31:0] wd,
                           input logic [31:0] rv, input int lat);
    logic [7:0] fb[$];
    logic [7:0] resp[$];
    bit valid, rd;
    int k, exp_strobe;
    valid = op == 8'h57 || op == 8'h52;
    rd    = op == 8'h52;
    fb = {op};
    if (valid) for (int i = 3; i >= 0; i--) fb.push_back(a[8*i +: 8]);
    if (op == 8'h57) for (int i = 3; i >= 0; i--) fb.push_back(wd[8*i +: 8]);
    if (!valid || lat >= TMO) resp = {8'h15};
    else begin
      resp = {8'h06};
      if (rd) for (int i = 3; i >= 0; i--) resp.push_back(rv[8*i +: 8]);
    end
    exp_strobe = !valid ? 0 : (lat < TMO ? lat + 1 : TMO);
    foreach (fb[i]) begin
      send_byte(fb[i]);
      if (i == 0) check("busy_rise", busy, 1);
      if (i < fb.size() - 1) begin
        check("cs_during_frame", cs_, 1);
        repeat ($urandom_range(0, 2)) tick;
      end
    end
    k = 0;
    if (valid) begin
      check("rw", rw, rd);
      check("addr", addr, a >> 2);
      if (!rd) check("wr_data", wr_data, wd);
      while (!cs_ && !as_ && k < 64) begin
        rdy_    = k != lat;
        rd_data = (k == lat) ? rv : $urandom;
        check("addr_hold", addr, a >> 2);
        check("tx_quiet_bus", tx_start, 0);
        tick;
        k++;
      end
    end else check("no_bus", cs_, 1);
    rdy_ = 1'b1;
    check("strobe_len", k, exp_strobe);
    foreach (resp[i]) begin
      check("tx_start", tx_start, 1);
      check("tx_data", tx_data, resp[i]);
      tick;
      check("tx_pulse", tx_start, 0);
      repeat ($urandom_range(0, 3)) begin
        if ($urandom_range(0, 1) == 1) begin
          rx_data = 8'($urandom);
          rx_end  = 1'b1;
        end
        rdy_    = 1'($urandom_range(0, 1));
        rd_data = $urandom;
        tick;
        rx_end = 1'b0;
        check("send_quiet", {tx_start, cs_}, 2'b01);
      end
      tx_end = 1'b1;
      tick;
      tx_end = 1'b0;
    end
    rdy_ = 1'b1;
    check("busy_fall", busy, 0);
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [7:0] op;
    repeat (2) tick;
    check("rst_cs", cs_, 1);
    check("rst_as", as_, 1);
    check("rst_rw", rw, 1);
    check("rst_addr", addr, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_tx_start", tx_start, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_busy", busy, 0);
    reset = 1'b1;
    tick;
    run_frame(8'h57, 32'h0000_0104, 32'hDEAD_BEEF, 32'h0, 3);
    run_frame(8'h52, 32'h0000_0008, 32'h0, 32'h1234_5678, 0);
    run_frame(8'h52, 32'h0000_1000, 32'h0, 32'hCAFE_F00D, 100);
    run_frame(8'h52, 32'h0000_0020, 32'h0, 32'hA5A5_A5A5, 1);
    run_frame(8'h41, 32'h0, 32'h0, 32'h0, 0);
    run_frame(8'h57, 32'h8000_0013, 32'h0102_0304, 32'h0, TMO - 1);
    run_frame(8'h52, 32'hFFFF_FFFC, 32'h0, 32'h0BAD_CAFE, TMO);
    send_byte(8'h57);
    for (int i = 0; i < 8; i++) send_byte(8'(i + 1));
    rdy_ = 1'b1;
    check("pre_rst_bus", cs_, 0);
    tick;
    #2 reset = 1'b0;
    #1;
    check("mid_rst_cs", cs_, 1);
    check("mid_rst_as", as_, 1);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_tx_start", tx_start, 0);
    check("mid_rst_addr", addr, 0);
    check("mid_rst_wr_data", wr_data, 0);
    @(negedge clk) reset = 1'b1;
    tick;
    check("post_rst_busy", busy, 0);
    run_frame(8'h52, 32'h0000_0444, 32'h0, 32'h5566_7788, 2);
    repeat (24) begin
      case ($urandom_range(0, 4))
        0, 1: op = 8'h57;
        2, 3: op = 8'h52;
        default: begin
          do op = 8'($urandom); while (op == 8'h57 || op == 8'h52);
        end
      endcase
      run_frame(op, $urandom, $urandom, $urandom, $urandom_range(0, 10));
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
